// File: rtl/ip_conf_slave.sv
// ip_conf_slave: IP-side responder for the conf_dbus host configuration interface.
// Provides MEM_IN/MEM_OUT buffers, auto-incrementing config registers, a maskable
// sticky status register, an ID register, the core start pulse and the interrupt.
// Optional macro ADDR_ERR_EN: unmapped accesses (and ID writes) set status flag 15.
module ip_conf_slave #(
    parameter logic [31:0] IP_ID         = 32'h0000_0001,
    parameter int unsigned MEM_IN_DEPTH  = 64,
    parameter int unsigned MEM_OUT_DEPTH = 64,
    parameter int unsigned NUM_CONF      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [4:0]                       conf_dbus,
    input  logic [31:0]                      data_in,
    input  logic                             read,
    input  logic                             write,
    input  logic                             start,
    output logic [31:0]                      data_out,
    output logic                             rd_valid,
    output logic                             int_req,
    output logic                             start_core,
    input  logic [$clog2(MEM_IN_DEPTH)-1:0]  mem_in_raddr,
    output logic [31:0]                      mem_in_rdata,
    input  logic                             mem_out_we,
    input  logic [$clog2(MEM_OUT_DEPTH)-1:0] mem_out_waddr,
    input  logic [31:0]                      mem_out_wdata,
    output logic [NUM_CONF*32-1:0]           conf_regs,
    input  logic [15:0]                      core_flags
);

    localparam int unsigned IW = $clog2(MEM_IN_DEPTH);
    localparam int unsigned OW = $clog2(MEM_OUT_DEPTH);
    localparam int unsigned CW = $clog2(NUM_CONF);

`ifdef ADDR_ERR_EN
    localparam bit AddrErrEn = 1'b1;
`else
    localparam bit AddrErrEn = 1'b0;
`endif

    localparam logic [4:0] AddrMemIn   = 5'h00;
    localparam logic [4:0] AddrMemOut  = 5'h01;
    localparam logic [4:0] AddrConf    = 5'h02;
    localparam logic [4:0] AddrInPtr   = 5'h03;
    localparam logic [4:0] AddrOutPtr  = 5'h04;
    localparam logic [4:0] AddrConfPtr = 5'h05;
    localparam logic [4:0] AddrStatus  = 5'h1E;
    localparam logic [4:0] AddrId      = 5'h1F;

    logic [31:0] mem_in  [MEM_IN_DEPTH];
    logic [31:0] mem_out [MEM_OUT_DEPTH];
    logic [31:0] conf_q  [NUM_CONF];

    logic [IW-1:0] in_ptr_q, in_ptr_d;
    logic [OW-1:0] out_ptr_q, out_ptr_d;
    logic [CW-1:0] conf_ptr_q, conf_ptr_d;
    logic [15:0]   mask_q, mask_d, flags_q, flags_d, flag_clr, flag_set;
    logic [31:0]   data_out_q, data_out_d, mem_in_rdata_q;
    logic          rd_valid_q, rd_valid_d, int_req_q, start_core_q, start_prev_q;
    logic          mem_in_we, conf_we, addr_err;

    // Decode host access; a simultaneous write wins and the read is dropped.
    always_comb begin
        in_ptr_d   = in_ptr_q;
        out_ptr_d  = out_ptr_q;
        conf_ptr_d = conf_ptr_q;
        mask_d     = mask_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        flag_clr   = 16'h0000;
        mem_in_we  = 1'b0;
        conf_we    = 1'b0;
        addr_err   = 1'b0;
        if (write) begin
            case (conf_dbus)
                AddrMemIn: begin
                    mem_in_we = 1'b1;
                    in_ptr_d  = in_ptr_q + 1'b1;
                end
                AddrMemOut: ;
                AddrConf: begin
                    conf_we    = 1'b1;
                    conf_ptr_d = conf_ptr_q + 1'b1;
                end
                AddrInPtr:   in_ptr_d   = data_in[IW-1:0];
                AddrOutPtr:  out_ptr_d  = data_in[OW-1:0];
                AddrConfPtr: conf_ptr_d = data_in[CW-1:0];
                AddrStatus: begin
                    mask_d   = data_in[31:16];
                    flag_clr = data_in[15:0];
                end
                default: addr_err = 1'b1;  // includes writes to the read-only ID
            endcase
        end else if (read) begin
            rd_valid_d = 1'b1;
            case (conf_dbus)
                AddrMemIn, AddrConf: data_out_d = 32'h0;
                AddrMemOut: begin
                    data_out_d = mem_out[out_ptr_q];
                    out_ptr_d  = out_ptr_q + 1'b1;
                end
                AddrInPtr:   data_out_d = 32'(in_ptr_q);
                AddrOutPtr:  data_out_d = 32'(out_ptr_q);
                AddrConfPtr: data_out_d = 32'(conf_ptr_q);
                AddrStatus:  data_out_d = {mask_q, flags_q};
                AddrId:      data_out_d = IP_ID;
                default: begin
                    data_out_d = 32'h0;
                    addr_err   = 1'b1;
                end
            endcase
        end
        // Sets are applied after clears so a same-cycle set wins.
        flag_set = core_flags;
        if (AddrErrEn) flag_set[15] = addr_err;
        flags_d = (flags_q & ~flag_clr) | flag_set;
    end

    // Control and status registers; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ptr_q       <= '0;
            out_ptr_q      <= '0;
            conf_ptr_q     <= '0;
            mask_q         <= '0;
            flags_q        <= '0;
            data_out_q     <= '0;
            rd_valid_q     <= 1'b0;
            int_req_q      <= 1'b0;
            start_core_q   <= 1'b0;
            start_prev_q   <= 1'b0;
            mem_in_rdata_q <= '0;
            for (int k = 0; k < NUM_CONF; k++) conf_q[k] <= '0;
        end else begin
            in_ptr_q       <= in_ptr_d;
            out_ptr_q      <= out_ptr_d;
            conf_ptr_q     <= conf_ptr_d;
            mask_q         <= mask_d;
            flags_q        <= flags_d;
            data_out_q     <= data_out_d;
            rd_valid_q     <= rd_valid_d;
            int_req_q      <= |(flags_q & mask_q);
            start_core_q   <= start & ~start_prev_q;
            start_prev_q   <= start;
            mem_in_rdata_q <= mem_in[mem_in_raddr];
            if (conf_we) conf_q[conf_ptr_q] <= data_in;
        end
    end

    // Buffer storage is not reset; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!rst && mem_in_we) mem_in[in_ptr_q] <= data_in;
        if (!rst && mem_out_we) mem_out[mem_out_waddr] <= mem_out_wdata;
    end

    for (genvar k = 0; k < NUM_CONF; k++) begin : g_conf
        assign conf_regs[32*k +: 32] = conf_q[k];
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign int_req      = int_req_q;
    assign start_core   = start_core_q;
    assign mem_in_rdata = mem_in_rdata_q;

endmodule
